// File: rtl/axi_decerr_slave.sv
// AXI4 default slave: terminates every transaction with DECERR (2'b11).
// Optional first-fault address capture when AXI_DECERR_CAPTURE_EN is defined.
module axi_decerr_slave #(
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData = DataWidth'(64'hBADC_AB1E_DEAD_BEEF)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // write address
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    // write data
    input  logic [DataWidth-1:0] w_data_i,
    input  logic                 w_last_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    // write response
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    // read address
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    // read data
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i
`ifdef AXI_DECERR_CAPTURE_EN
    ,
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    input  logic                 err_clr_i
`endif
);

    localparam int unsigned LenWidth = 8;
    localparam logic [1:0]  DecErr   = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    w_state_e              w_state;
    r_state_e              r_state;
    logic [LenWidth-1:0]   beat_cnt;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign w_hs  = w_valid_i & w_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    // Response payload never varies, so it is tied off rather than stored.
    assign b_resp_o = DecErr;
    assign r_resp_o = DecErr;
    assign r_data_o = RespData;

    // Write channel: accept AW, sink W beats up to WLAST, then return B.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state    <= W_IDLE;
            aw_ready_o <= 1'b1;
            w_ready_o  <= 1'b0;
            b_valid_o  <= 1'b0;
            b_id_o     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        b_id_o     <= aw_id_i;
                        aw_ready_o <= 1'b0;
                        w_ready_o  <= 1'b1;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs && w_last_i) begin
                        w_ready_o <= 1'b0;
                        b_valid_o <= 1'b1;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_o  <= 1'b0;
                        aw_ready_o <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
                default: begin
                    w_state    <= W_IDLE;
                    aw_ready_o <= 1'b1;
                    w_ready_o  <= 1'b0;
                    b_valid_o  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel: counter holds beats remaining after the current one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= R_IDLE;
            ar_ready_o <= 1'b1;
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_id_o     <= '0;
            beat_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id_o     <= ar_id_i;
                        beat_cnt   <= ar_len_i;
                        r_last_o   <= (ar_len_i == LenWidth'(0));
                        r_valid_o  <= 1'b1;
                        ar_ready_o <= 1'b0;
                        r_state    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        if (beat_cnt == LenWidth'(0)) begin
                            r_valid_o  <= 1'b0;
                            r_last_o   <= 1'b0;
                            ar_ready_o <= 1'b1;
                            r_state    <= R_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - LenWidth'(1);
                            r_last_o <= (beat_cnt == LenWidth'(1));
                        end
                    end
                end
                default: begin
                    r_state    <= R_IDLE;
                    ar_ready_o <= 1'b1;
                    r_valid_o  <= 1'b0;
                    r_last_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_DECERR_CAPTURE_EN
    // Sticky first-fault capture; a clear coinciding with a fault re-arms on that fault.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end else if ((aw_hs || ar_hs) && (!err_valid_o || err_clr_i)) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= aw_hs ? aw_addr_i : ar_addr_i;
        end else if (err_clr_i) begin
            err_valid_o <= 1'b0;
        end
    end
`endif

    // Write data and, without capture, the addresses carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{w_data_i, aw_addr_i, ar_addr_i};

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed scoreboard bench for axi_decerr_slave (capture checks under AXI_DECERR_CAPTURE_EN).
module tb_axi_decerr_slave;

    localparam int unsigned IdW   = 6;
    localparam int unsigned AddrW = 64;
    localparam int unsigned DataW = 64;
    localparam logic [63:0] RESP  = 64'hBADC_AB1E_DEAD_BEEF;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [IdW-1:0]   aw_id_i;
    logic [AddrW-1:0] aw_addr_i;
    logic             aw_valid_i;
    logic             aw_ready_o;
    logic [DataW-1:0] w_data_i;
    logic             w_last_i;
    logic             w_valid_i;
    logic             w_ready_o;
    logic [IdW-1:0]   b_id_o;
    logic [1:0]       b_resp_o;
    logic             b_valid_o;
    logic             b_ready_i;
    logic [IdW-1:0]   ar_id_i;
    logic [AddrW-1:0] ar_addr_i;
    logic [7:0]       ar_len_i;
    logic             ar_valid_i;
    logic             ar_ready_o;
    logic [IdW-1:0]   r_id_o;
    logic [DataW-1:0] r_data_o;
    logic [1:0]       r_resp_o;
    logic             r_last_o;
    logic             r_valid_o;
    logic             r_ready_i;
`ifdef AXI_DECERR_CAPTURE_EN
    logic             err_valid_o;
    logic [AddrW-1:0] err_addr_o;
    logic             err_clr_i;
`endif

    axi_decerr_slave dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aw_id_i    (aw_id_i),
        .aw_addr_i  (aw_addr_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .w_data_i   (w_data_i),
        .w_last_i   (w_last_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .ar_id_i    (ar_id_i),
        .ar_addr_i  (ar_addr_i),
        .ar_len_i   (ar_len_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i)
`ifdef AXI_DECERR_CAPTURE_EN
        ,
        .err_valid_o(err_valid_o),
        .err_addr_o (err_addr_o),
        .err_clr_i  (err_clr_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IdW-1:0] id;
        logic           last;
    } rexp_t;

    rexp_t          rq[$];
    logic [IdW-1:0] bq[$];
    int             total = 0;
    int             bad   = 0;
    int             r_beats = 0;
    logic           mon_en = 1'b0;
    logic           r_stall_q = 1'b0;
    logic           b_stall_q = 1'b0;
    logic [79:0]    r_snap;
    logic [79:0]    b_snap;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk_i) begin
        if (rst_i || !mon_en) begin
            r_stall_q = 1'b0;
            b_stall_q = 1'b0;
        end else begin
            if (r_stall_q)
                check("r_hold", {r_valid_o, r_id_o, r_last_o, r_data_o, r_resp_o}, r_snap);
            if (b_stall_q)
                check("b_hold", {b_valid_o, b_id_o, b_resp_o}, b_snap);
            if (r_valid_o && r_ready_i) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check("r_id", r_id_o, e.id);
                    check("r_last", r_last_o, e.last);
                    check("r_data", r_data_o, RESP);
                    check("r_resp", r_resp_o, 2'b11);
                    r_beats++;
                end
            end
            if (b_valid_o && b_ready_i) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    check("b_id", b_id_o, bq.pop_front());
                    check("b_resp", b_resp_o, 2'b11);
                end
            end
            r_stall_q = r_valid_o && !r_ready_i;
            r_snap    = {r_valid_o, r_id_o, r_last_o, r_data_o, r_resp_o};
            b_stall_q = b_valid_o && !b_ready_i;
            b_snap    = {b_valid_o, b_id_o, b_resp_o};
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_reads(input logic [IdW-1:0] id, input int len);
        for (int i = 0; i <= len; i++) begin
            rexp_t e;
            e.id   = id;
            e.last = (i == len);
            rq.push_back(e);
        end
    endtask

    task automatic send_ar(input logic [IdW-1:0] id, input logic [7:0] len, input logic [63:0] addr);
        logic hs;
        int   n;
        push_reads(id, int'(len));
        ar_valid_i = 1'b1;
        ar_id_i    = id;
        ar_len_i   = len;
        ar_addr_i  = addr;
        n = 0;
        do begin
            @(negedge clk_i);
            hs = ar_ready_o;
            step();
            n++;
        end while (!hs && n < 50);
        ar_valid_i = 1'b0;
        check("ar_accept", hs, 1);
    endtask

    task automatic send_aw(input logic [IdW-1:0] id, input logic [63:0] addr);
        logic hs;
        int   n;
        bq.push_back(id);
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_addr_i  = addr;
        n = 0;
        do begin
            @(negedge clk_i);
            hs = aw_ready_o;
            step();
            n++;
        end while (!hs && n < 50);
        aw_valid_i = 1'b0;
        check("aw_accept", hs, 1);
    endtask

    task automatic send_w(input logic last);
        logic hs;
        int   n;
        w_valid_i = 1'b1;
        w_last_i  = last;
        w_data_i  = {$urandom, $urandom};
        n = 0;
        do begin
            @(negedge clk_i);
            hs = w_ready_o;
            step();
            n++;
        end while (!hs && n < 50);
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        check("w_accept", hs, 1);
    endtask

    task automatic wait_done(input string tag, input int budget, input logic rand_ready);
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < budget) begin
            if (rand_ready) r_ready_i = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        r_ready_i = 1'b1;
        check(tag, rq.size() + bq.size(), 0);
    endtask

    initial begin
        int b0;
        rst_i = 1'b1; aw_id_i = '0; aw_addr_i = '0; aw_valid_i = 1'b0;
        w_data_i = '0; w_last_i = 1'b0; w_valid_i = 1'b0; b_ready_i = 1'b1;
        ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_valid_i = 1'b0; r_ready_i = 1'b1;
`ifdef AXI_DECERR_CAPTURE_EN
        err_clr_i = 1'b0;
`endif
        step(); step();
        rst_i = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_i);
        check("rst_aw_ready", aw_ready_o, 1);
        check("rst_ar_ready", ar_ready_o, 1);
        check("rst_w_ready", w_ready_o, 0);
        check("rst_b_valid", b_valid_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_r_last", r_last_o, 0);
        check("rst_ids", {b_id_o, r_id_o}, 0);
`ifdef AXI_DECERR_CAPTURE_EN
        check("rst_err", {err_valid_o, err_addr_o}, 0);
`endif
        step();

        // Single write, B the cycle after WLAST
        send_aw(6'h2A, 64'h5000_0000);
        send_w(1'b1);
        @(negedge clk_i);
        check("b_after_wlast", b_valid_o, 1);
        step();
        wait_done("wr1_done", 20, 1'b0);

        // Multi-beat write ends only on WLAST
        send_aw(6'h15, 64'h5000_0100);
        send_w(1'b0);
        send_w(1'b0);
        @(negedge clk_i);
        check("b_not_before_last", b_valid_o, 0);
        step();
        send_w(1'b1);
        wait_done("wr2_done", 20, 1'b0);

        // Read burst len=3
        b0 = r_beats;
        send_ar(6'h11, 8'd3, 64'h5000_0200);
        @(negedge clk_i);
        check("r_first_lat", r_valid_o, 1);
        step();
        wait_done("rd4_done", 20, 1'b0);
        @(negedge clk_i);
        check("rd4_beats", r_beats - b0, 4);
        check("rd4_ar_ready", ar_ready_o, 1);
        check("rd4_r_valid_off", r_valid_o, 0);
        step();

        // len=255 with random backpressure
        b0 = r_beats;
        r_ready_i = 1'b0;
        send_ar(6'h3F, 8'd255, 64'h5000_0300);
        wait_done("rd256_done", 3000, 1'b1);
        @(negedge clk_i);
        check("rd256_beats", r_beats - b0, 256);
        check("rd256_r_valid_off", r_valid_o, 0);
        step();

        // Early W stalled, AW+AR together, independent completion
        w_valid_i = 1'b1; w_last_i = 1'b1; w_data_i = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("w_early_stall", w_ready_o, 0);
            step();
        end
        b_ready_i = 1'b0;
        aw_valid_i = 1'b1; aw_id_i = 6'h05; aw_addr_i = 64'h5000_0400;
        ar_valid_i = 1'b1; ar_id_i = 6'h0C; ar_len_i = 8'd1; ar_addr_i = 64'h5000_0500;
        bq.push_back(6'h05);
        push_reads(6'h0C, 1);
        @(negedge clk_i);
        check("both_ready", {aw_ready_o, ar_ready_o, w_ready_o}, 3'b110);
        step();
        aw_valid_i = 1'b0; ar_valid_i = 1'b0;
        @(negedge clk_i);
        check("both_taken", {aw_ready_o, ar_ready_o, w_ready_o, r_valid_o}, 4'b0011);
        step();
        w_valid_i = 1'b0; w_last_i = 1'b0;
        @(negedge clk_i);
        check("b_pending", b_valid_o, 1);
        step(); step(); step();
        @(negedge clk_i);
        check("b_held", {b_valid_o, aw_ready_o}, 2'b10);
        step();
        b_ready_i = 1'b1;
        wait_done("conc_done", 20, 1'b0);

        // Reset during beat 2 of len=7
        send_ar(6'h22, 8'd7, 64'h5000_0600);
        @(negedge clk_i);
        check("mid_beat1", r_valid_o, 1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        rq.delete();
        @(negedge clk_i);
        check("mid_rst_r_valid", r_valid_o, 0);
        check("mid_rst_ar_ready", ar_ready_o, 1);
        check("mid_rst_r_last", r_last_o, 0);
`ifdef AXI_DECERR_CAPTURE_EN
        check("mid_rst_err", {err_valid_o, err_addr_o}, 0);
`endif
        step();
        b0 = r_beats;
        send_ar(6'h07, 8'd0, 64'h6000_0000);
        wait_done("len0_done", 20, 1'b0);
        @(negedge clk_i);
        check("len0_beats", r_beats - b0, 1);
        step();

        send_ar(6'h08, 8'd0, 64'h7000_0000);
        wait_done("rd7_done", 20, 1'b0);
`ifdef AXI_DECERR_CAPTURE_EN
        @(negedge clk_i);
        check("err_first", {err_valid_o, err_addr_o}, {1'b1, 64'h6000_0000});
        step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        @(negedge clk_i);
        check("err_cleared", err_valid_o, 0);
        step();
        send_aw(6'h09, 64'h7000_0000);
        send_w(1'b1);
        wait_done("wr7_done", 20, 1'b0);
        @(negedge clk_i);
        check("err_second", {err_valid_o, err_addr_o}, {1'b1, 64'h7000_0000});
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- AXI4 terminating slave on the SoC crossbar's default (no-match) port. It receives every master transaction whose address falls outside all ten peripheral windows, from DebugBase through DRAMBase.
- Completes each transaction protocol-correctly with a DECERR response, so a stray access from a hart or the debug module raises a bus error instead of hanging the interconnect.
- Read and write channels are handled by two independent state machines. Each channel has at most one transaction outstanding.

Parameters:
- IdWidth, 6, slave-side AXI ID width (master IdWidth 4 + clog2(NrSlaves=3)).
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width.
- RespData, 64'hBADC_AB1E_DEAD_BEEF, constant driven on rdata for every error read beat.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- aw_id_i  in  IdWidth  write address ID
- aw_addr_i  in  AddrWidth  write address
- aw_valid_i  in  1  AW valid
- aw_ready_o  out  1  AW ready
- w_data_i  in  DataWidth  write data (discarded)
- w_last_i  in  1  last write beat
- w_valid_i  in  1  W valid
- w_ready_o  out  1  W ready
- b_id_o  out  IdWidth  write response ID
- b_resp_o  out  2  write response, always 2'b11
- b_valid_o  out  1  B valid
- b_ready_i  in  1  B ready
- ar_id_i  in  IdWidth  read address ID
- ar_addr_i  in  AddrWidth  read address
- ar_len_i  in  8  burst length minus one
- ar_valid_i  in  1  AR valid
- ar_ready_o  out  1  AR ready
- r_id_o  out  IdWidth  read ID
- r_data_o  out  DataWidth  read data
- r_resp_o  out  2  read response, always 2'b11
- r_last_o  out  1  last read beat
- r_valid_o  out  1  R valid
- r_ready_i  in  1  R ready

Behaviour:
- Single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: aw_ready_o=1, ar_ready_o=1, w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0. b_id_o, r_id_o and the beat counter are 0.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready_o=1, w_ready_o=0. On an AW handshake, latch aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Each W handshake is consumed. A handshake with w_last_i=1 goes to W_RESP. A handshake without w_last_i stays in W_DATA.
  - W_RESP: b_valid_o=1, b_id_o=latched ID, b_resp_o=2'b11. A B handshake returns to W_IDLE.
  - The beat count is taken from w_last_i only; awlen is not needed.
  - W beats presented before their AW are stalled (w_ready_o=0 in W_IDLE).
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready_o=1. On an AR handshake, latch ar_id_i, load the 8-bit counter with ar_len_i, and go to R_DATA.
  - R_DATA: r_valid_o=1, r_data_o=RespData, r_resp_o=2'b11, r_id_o=latched ID, r_last_o=(counter==0).
  - Each R handshake with the counter nonzero decrements the counter. A handshake with counter==0 returns to R_IDLE.
  - arlen=0 gives exactly 1 beat; arlen=255 gives exactly 256 beats with no wrap-around.
- Latency:
  - First R beat is valid the cycle after the AR handshake.
  - B is valid the cycle after the WLAST handshake.
  - Back-to-back transactions: the next AW/AR is accepted the cycle after B/last-R completes, giving 1 idle cycle minimum.
- Handshake rules:
  - While b_valid_o or r_valid_o is asserted, its payload is held stable until ready.
  - r_ready_i/b_ready_i held low stalls the FSM indefinitely without dropping valid.
- Simultaneous events: read and write channels are fully independent. A concurrent AW and AR in the same cycle are both accepted.
- Reset mid-operation: rst_i asserted in any state forces both FSMs to IDLE at the next edge and drops valid outputs. The partial transaction is abandoned and the master side is reset with it.

Optional Feature:
- Macro: AXI_DECERR_CAPTURE_EN.
- When defined, three ports are added:
  - err_valid_o, out, 1.
  - err_addr_o, out, AddrWidth.
  - err_clr_i, in, 1.
- On the first AW or AR handshake while err_valid_o=0, the address is captured (aw_addr_i has priority if both fire in the same cycle) and err_valid_o is set sticky.
- Later faults do not overwrite the captured address.
- err_clr_i=1 clears err_valid_o on the next edge. If clear coincides with a new fault, the new address is captured and err_valid_o stays 1.
- Reset clears both err_valid_o and err_addr_o.
- When the macro is undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single write: AW id=6'h2A, addr=64'h5000_0000, one W beat with wlast -> B beat bid=6'h2A, bresp=2'b11, the cycle after WLAST.
- Read burst: AR id=6'h11, len=3, r_ready always 1 -> 4 beats rdata=RespData, rresp=2'b11, rlast on beat 4 only, then ar_ready=1.
- Backpressure: AR len=255 with r_ready toggling randomly -> exactly 256 beats, payload stable while stalled, rlast only on beat 256.
- Concurrency/ordering: AW and AR same cycle, with W presented 3 cycles before AW -> both accepted, W stalled until W_DATA, independent completion.
- Reset mid-burst: assert rst_i on beat 2 of a len=7 read -> r_valid=0 next cycle, ar_ready=1, a new AR len=0 returns exactly 1 beat.
- AXI_DECERR_CAPTURE_EN: reads at 64'h6000_0000 then 64'h7000_0000 -> err_addr_o=64'h6000_0000; after err_clr_i pulse and a write to 64'h7000_0000 -> err_addr_o=64'h7000_0000.
